// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one Sysbus request/response channel between the
// instruction-fetch requester (line reads) and the data requester (line
// reads/writes), one transaction in flight at a time.
// Ports:
//   clk, reset                 clock, async active-high reset
//   fetch_valid/addr/ack       fetch read request handshake
//   fetch_rvalid/rdata         fetch response beats
//   data_valid/write/addr/ack  data request handshake
//   data_wready/wdata          data write beats
//   data_rvalid/rdata          data response beats
//   bus_reqcyc/req/reqtag/ack  Sysbus request channel
//   bus_respcyc/resp/resptag   Sysbus response channel
//   bus_respack                Sysbus response accept
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// left undefined, data has fixed priority over fetch.

module sysbus_arbiter #(
  parameter int         ADDR_W   = 64,
  parameter int         DATA_W   = 64,
  parameter int         TAG_W    = 13,
  parameter int         BEATS    = 8,
  parameter logic [7:0] FETCH_ID = 8'h00,
  parameter logic [7:0] DATA_ID  = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_valid,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_ack,
  output logic              data_wready,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_reqcyc,
  output logic [DATA_W-1:0] bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [DATA_W-1:0] bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag,
  output logic              bus_respack
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [3:0] MEM_SPACE = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WDATA
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              any_valid;
  logic              grant_data;
  logic              last_beat;

  function automatic logic [DATA_W-1:0] line_of(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] m;
    m = a & ~ADDR_W'(63);
    return DATA_W'(m);
  endfunction

  assign any_valid = fetch_valid || data_valid;
  assign last_beat = (cnt_q == LAST_BEAT);

`ifdef ARB_ROUND_ROBIN_EN
  // Resets to "data last", so fetch takes the first tie.
  logic last_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_q <= 1'b1;
    end else if (state_q == S_IDLE && any_valid) begin
      last_data_q <= grant_data;
    end
  end

  assign grant_data =
    data_valid && (!fetch_valid || !last_data_q);
`else
  assign grant_data = data_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    tag_d        = tag_q;
    fetch_ack    = 1'b0;
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    data_ack     = 1'b0;
    data_wready  = 1'b0;
    data_rvalid  = 1'b0;
    data_rdata   = '0;
    bus_reqcyc   = 1'b0;
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          owner_d = grant_data;
          wr_d    = grant_data && data_write;
          addr_d  = grant_data ? line_of(data_addr)
                               : line_of(fetch_addr);
          tag_d   = TAG_W'({
            ~wr_d, MEM_SPACE,
            grant_data ? DATA_ID : FETCH_ID
          });
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = tag_q;
        if (bus_reqack) begin
          fetch_ack = !owner_q;
          data_ack  = owner_q;
          state_d   = wr_q ? S_WDATA : S_RESP;
        end
      end

      // Write beats flow one per cycle straight from the requester.
      S_WDATA: begin
        bus_reqcyc  = 1'b1;
        bus_req     = data_wdata;
        bus_reqtag  = tag_q;
        data_wready = 1'b1;
        if (last_beat) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Beats are forwarded with no latency; gaps are allowed.
      S_RESP: begin
        bus_respack = bus_respcyc;
        if (owner_q) begin
          data_rvalid = bus_respcyc;
          data_rdata  = bus_respcyc ? bus_resp : '0;
        end else begin
          fetch_rvalid = bus_respcyc;
          fetch_rdata  = bus_respcyc ? bus_resp : '0;
        end
        if (bus_respcyc) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The response tag is only inspected by the checks below.
  logic unused_resptag;
  assign unused_resptag = ^bus_resptag;

`ifndef SYNTHESIS
  logic [7:0] owner_id;
  assign owner_id = owner_q ? DATA_ID : FETCH_ID;

  a_resp_owner: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == S_RESP && bus_respcyc)
      |-> (bus_resptag[7:0] == owner_id)
  ) else $error("sysbus_arbiter: resp tag id not owner");

  a_resp_state: assert property (
    @(posedge clk) disable iff (reset)
    bus_respcyc |-> (state_q == S_RESP)
  ) else $error("sysbus_arbiter: resp beat outside RESP");
`endif

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed tests for sysbus_arbiter.
// Inputs change on the falling edge; outputs are checked 1ns later.

module tb_sysbus_arbiter;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [63:0] fetch_addr;
  logic        fetch_ack;
  logic        fetch_rvalid;
  logic [63:0] fetch_rdata;
  logic        data_valid;
  logic        data_write;
  logic [63:0] data_addr;
  logic        data_ack;
  logic        data_wready;
  logic [63:0] data_wdata;
  logic        data_rvalid;
  logic [63:0] data_rdata;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  int checks = 0;
  int errors = 0;

  sysbus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .data_valid   (data_valid),
    .data_write   (data_write),
    .data_addr    (data_addr),
    .data_ack     (data_ack),
    .data_wready  (data_wready),
    .data_wdata   (data_wdata),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .bus_reqcyc   (bus_reqcyc),
    .bus_req      (bus_req),
    .bus_reqtag   (bus_reqtag),
    .bus_reqack   (bus_reqack),
    .bus_respcyc  (bus_respcyc),
    .bus_resp     (bus_resp),
    .bus_resptag  (bus_resptag),
    .bus_respack  (bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    data_valid  = 1'b0;
    data_write  = 1'b0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    reset = 1'b1;
    clear_inputs();
    #1;
    flags = {fetch_ack, fetch_rvalid, data_ack, data_wready,
             data_rvalid, bus_reqcyc, bus_respack};
    checks++;
    if (flags !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0", flags);
    end
    checks++;
    if ({bus_req, bus_reqtag, fetch_rdata, data_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0",
               bus_req, bus_reqtag);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch_read();
    int bad;
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 64'h1234;
    #1;
    checks++;
    if (bus_reqcyc !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle_reqcyc got %b want 0", bus_reqcyc);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag, fetch_ack}
        !== {1'b1, 64'h1200, 13'h1100, 1'b0}) begin
      errors++;
      $display("FAIL rd_req got cyc=%b req=%h tag=%h ack=%b want 1 1200 1100 0",
               bus_reqcyc, bus_req, bus_reqtag, fetch_ack);
    end
    bus_reqack = 1'b1;
    #1;
    checks++;
    if ({fetch_ack, data_ack} !== 2'b10) begin
      errors++;
      $display("FAIL rd_ack got %b%b want 10", fetch_ack, data_ack);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fetch_valid = 1'b0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b1;
      bus_resp    = 64'hA0 + 64'(i);
      bus_resptag = 13'h1100;
      #1;
      if ({fetch_rvalid, data_rvalid, bus_respack,
           bus_reqcyc, fetch_ack} !== 5'b10100 ||
          fetch_rdata !== 64'hA0 + 64'(i))
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rd_beats got %0d bad beats want 0", bad);
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 64'h1FC0;
    #1;
    checks++;
    if ({fetch_rvalid, bus_respack, bus_reqcyc} !== 3'b000) begin
      errors++;
      $display("FAIL rd_end got %b%b%b want 000",
               fetch_rvalid, bus_respack, bus_reqcyc);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    #1;
    checks++;
    if ({bus_reqcyc, bus_req} !== {1'b1, 64'h1FC0}) begin
      errors++;
      $display("FAIL rd_turnaround got %b %h want 1 1fc0",
               bus_reqcyc, bus_req);
    end
    bus_reqack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b1;
      bus_resptag = 13'h1100;
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
  endtask

  task automatic test_data_write();
    int bad;
    @(negedge clk);
    data_valid = 1'b1;
    data_write = 1'b1;
    data_addr  = 64'h2040;
    data_wdata = 64'hD0;
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag, data_ack, fetch_ack}
        !== {1'b1, 64'h2040, 13'h0101, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_req got cyc=%b req=%h tag=%h ack=%b want 1 2040 0101 1",
               bus_reqcyc, bus_req, bus_reqtag, data_ack);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      bus_reqack = 1'b0;
      data_wdata = 64'hD0 + 64'(i);
      #1;
      if ({bus_reqcyc, data_wready, data_ack, bus_respack}
          !== 4'b1100 || bus_req !== 64'hD0 + 64'(i) ||
          bus_reqtag !== 13'h0101)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wr_beats got %0d bad beats want 0", bad);
    end
    @(negedge clk);
    data_write = 1'b0;
    #1;
    checks++;
    if ({bus_reqcyc, data_wready, data_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL wr_end got %b%b%b want 000",
               bus_reqcyc, data_wready, data_rvalid);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_d;
    logic       is_d;
    int         own_n;
    int         other_n;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 4'b1010;
`else
    exp_d = 4'b1111;
`endif
    do_reset();
    fetch_addr = 64'h3000;
    data_addr  = 64'h4000;
    data_write = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      bus_respcyc = 1'b0;
      fetch_valid = 1'b1;
      data_valid  = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b1;
      #1;
      is_d = data_ack;
      checks++;
      if ({data_ack, fetch_ack} !== {exp_d[t], ~exp_d[t]}) begin
        errors++;
        $display("FAIL arb_winner_%0d got d=%b f=%b want d=%b",
                 t, data_ack, fetch_ack, exp_d[t]);
      end
      own_n   = 0;
      other_n = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = 64'(t * 16 + i);
        bus_resptag = is_d ? 13'h1101 : 13'h1100;
        #1;
        if (is_d) begin
          if (data_rvalid === 1'b1 && data_rdata === bus_resp)
            own_n++;
          if (fetch_rvalid !== 1'b0) other_n++;
        end else begin
          if (fetch_rvalid === 1'b1 && fetch_rdata === bus_resp)
            own_n++;
          if (data_rvalid !== 1'b0) other_n++;
        end
      end
      checks++;
      if (own_n !== 8 || other_n !== 0) begin
        errors++;
        $display("FAIL arb_steer_%0d got own=%0d other=%0d want 8 0",
                 t, own_n, other_n);
      end
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    fetch_valid = 1'b0;
    data_valid  = 1'b0;
  endtask

  task automatic test_wait_gaps();
    int bad;
    int rv;
    do_reset();
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 64'h5678;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if ({bus_reqcyc, bus_req, bus_reqtag, fetch_ack}
          !== {1'b1, 64'h5640, 13'h1100, 1'b0})
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gap_req_stable got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    checks++;
    if ({fetch_ack, bus_req} !== {1'b1, 64'h5640}) begin
      errors++;
      $display("FAIL gap_ack got %b %h want 1 5640",
               fetch_ack, bus_req);
    end
    bad = 0;
    rv  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fetch_valid = 1'b0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b1;
      bus_resp    = 64'hB0 + 64'(i);
      bus_resptag = 13'h1100;
      #1;
      if (fetch_rvalid === 1'b1) rv++;
      if (fetch_rdata !== 64'hB0 + 64'(i) || bus_respack !== 1'b1)
        bad++;
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        bus_respcyc = 1'b0;
        bus_resp    = 64'hFF;
        #1;
        if (fetch_rvalid !== 1'b0 || bus_respack !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad !== 0 || rv !== 8) begin
      errors++;
      $display("FAIL gap_beats got bad=%0d rvalid=%0d want 0 8", bad, rv);
    end
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 64'h9000;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_reqcyc, bus_req} !== {1'b1, 64'h9000}) begin
      errors++;
      $display("FAIL gap_exact8 got %b %h want 1 9000",
               bus_reqcyc, bus_req);
    end
  endtask

  task automatic test_reset_mid_resp();
    int bad;
    do_reset();
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 64'h6000;
    @(negedge clk);
    bus_reqack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch_valid = 1'b0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b1;
      bus_resptag = 13'h1100;
      bus_resp    = 64'hC0 + 64'(i);
    end
    @(negedge clk);
    bus_resp = 64'hC3;
    #1;
    checks++;
    if (fetch_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got %b want 1", fetch_rvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({fetch_rvalid, bus_respack, bus_reqcyc, fetch_rdata}
        !== '0) begin
      errors++;
      $display("FAIL rst_mid got rv=%b ack=%b cyc=%b want 0",
               fetch_rvalid, bus_respack, bus_reqcyc);
    end
    bus_respcyc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 64'h70A8;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag}
        !== {1'b1, 64'h7080, 13'h1100}) begin
      errors++;
      $display("FAIL rst_reissue got %b %h %h want 1 7080 1100",
               bus_reqcyc, bus_req, bus_reqtag);
    end
    bus_reqack = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fetch_valid = 1'b0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b1;
      bus_resp    = 64'hE0 + 64'(i);
      #1;
      if (fetch_rvalid !== 1'b1 || fetch_rdata !== 64'hE0 + 64'(i))
        bad++;
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    #1;
    checks++;
    if (bad !== 0 || fetch_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got bad=%0d rv=%b want 0 0",
               bad, fetch_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_arbitration();
    test_wait_gaps();
    test_reset_mid_resp();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want done");
    $fatal(1, "timeout");
  end

endmodule
